// File: rtl/clint_pkg.sv
// Shared definitions for the CLINT block: register offsets, AXI response
// codes, FSM state encodings, register decode and byte-strobe merge helpers.
package clint_pkg;

    localparam int unsigned MAX_HART = 4;

    localparam logic [15:0] MSIP_BASE     = 16'h0000;
    localparam logic [15:0] MTIMECMP_BASE = 16'h4000;
    localparam logic [15:0] MTIME_LO      = 16'hBFF8;
    localparam logic [15:0] MTIME_HI      = 16'hBFFC;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {R_IDLE, R_RESP} r_state_t;
    typedef enum logic {W_IDLE, W_RESP} w_state_t;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_MSIP,
        REG_CMP_LO,
        REG_CMP_HI,
        REG_TIME_LO,
        REG_TIME_HI
    } reg_kind_t;

    typedef struct packed {
        reg_kind_t  kind;
        logic [1:0] hart;
    } reg_sel_t;

    // Map a 16-bit offset to a register; anything not listed, or a hart
    // index at or beyond nhart, decodes to REG_NONE.
    function automatic reg_sel_t decode(input logic [15:0] off, input int unsigned nhart);
        reg_sel_t sel;
        sel.kind = REG_NONE;
        sel.hart = 2'd0;
        if (off == MTIME_LO) begin
            sel.kind = REG_TIME_LO;
        end else if (off == MTIME_HI) begin
            sel.kind = REG_TIME_HI;
        end else begin
            for (int unsigned h = 0; h < MAX_HART; h++) begin
                if (h < nhart) begin
                    if (off == MSIP_BASE + 16'(4 * h)) begin
                        sel.kind = REG_MSIP;
                        sel.hart = 2'(h);
                    end
                    if (off == MTIMECMP_BASE + 16'(8 * h)) begin
                        sel.kind = REG_CMP_LO;
                        sel.hart = 2'(h);
                    end
                    if (off == MTIMECMP_BASE + 16'(8 * h + 4)) begin
                        sel.kind = REG_CMP_HI;
                        sel.hart = 2'(h);
                    end
                end
            end
        end
        return sel;
    endfunction

    // Replace the bytes of old selected by strb with the matching bytes of data.
    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                          input logic [3:0] strb);
        logic [31:0] res;
        res = old;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = data[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/clint_timer.sv
// mtime counter with prescaler and software load of either 32-bit half.
// Ports: clk, rst (sync, active-high); wr_lo/wr_hi load strobes with
// wdata/wstrb byte-merged payload; mtime is the current 64-bit time.
module clint_timer
    import clint_pkg::*;
#(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic [63:0] mtime
);

    localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0] pre;
    logic             tick;

    assign tick = (pre == PRE_MAX);

    // Prescaler runs freely; a software load does not disturb its phase.
    always_ff @(posedge clk) begin
        if (rst) pre <= '0;
        else if (tick) pre <= '0;
        else pre <= pre + PRE_W'(1);
    end

    // A load takes priority and swallows a coincident tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            mtime <= '0;
        end else if (wr_lo) begin
            mtime[31:0] <= merge(mtime[31:0], wdata, wstrb);
        end else if (wr_hi) begin
            mtime[63:32] <= merge(mtime[63:32], wdata, wstrb);
        end else if (tick) begin
            mtime <= mtime + 64'd1;
        end
    end

endmodule

// File: rtl/clint_axi.sv
// Core-local interruptor with an AXI4-Lite slave port.
// Ports: clk, rst (sync, active-high); AXI4-Lite AR/R and AW/W/B channels
// (one outstanding read, one outstanding write, independent of each other);
// msip[NHART] software interrupts, mtip[NHART] registered timer interrupts.
module clint_axi
    import clint_pkg::*;
#(
    parameter int unsigned NHART    = 1,
    parameter int unsigned TICK_DIV = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arvalid,
    output logic              arready,
    input  logic [31:0]       araddr,
    output logic              rvalid,
    input  logic              rready,
    output logic [31:0]       rdata,
    output logic [1:0]        rresp,
    input  logic              awvalid,
    output logic              awready,
    input  logic [31:0]       awaddr,
    input  logic              wvalid,
    output logic              wready,
    input  logic [31:0]       wdata,
    input  logic [3:0]        wstrb,
    output logic              bvalid,
    input  logic              bready,
    output logic [1:0]        bresp,
    output logic [NHART-1:0]  msip,
    output logic [NHART-1:0]  mtip
);

    r_state_t r_state, r_state_next;
    w_state_t w_state, w_state_next;

    reg_sel_t rd_sel, wr_sel;
    logic [31:0] rd_data;
    logic [1:0]  rd_resp;
    logic        wr_en;

    logic [MAX_HART-1:0] msip_q;
    logic [63:0]         mtimecmp [MAX_HART];
    logic [63:0]         mtime;

    // Only the low 16 address bits take part in decode.
    logic unused_addr;
    assign unused_addr = ^{araddr[31:16], awaddr[31:16]};

    assign rd_sel = decode(araddr[15:0], NHART);
    assign wr_sel = decode(awaddr[15:0], NHART);

    // Read data mux over current register state (pre-write on a collision).
    always_comb begin
        rd_data = 32'd0;
        rd_resp = RESP_OKAY;
        case (rd_sel.kind)
            REG_MSIP:    rd_data = {31'd0, msip_q[rd_sel.hart]};
            REG_CMP_LO:  rd_data = mtimecmp[rd_sel.hart][31:0];
            REG_CMP_HI:  rd_data = mtimecmp[rd_sel.hart][63:32];
            REG_TIME_LO: rd_data = mtime[31:0];
            REG_TIME_HI: rd_data = mtime[63:32];
            default:     rd_resp = RESP_SLVERR;
        endcase
    end

    // Read FSM state register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= R_IDLE;
        else r_state <= r_state_next;
    end

    // Read FSM next state; arready follows arvalid while idle.
    always_comb begin
        r_state_next = r_state;
        arready      = 1'b0;
        case (r_state)
            R_IDLE: begin
                if (arvalid && !rst) begin
                    arready      = 1'b1;
                    r_state_next = R_RESP;
                end
            end
            R_RESP: begin
                if (rready) r_state_next = R_IDLE;
            end
            default: r_state_next = R_IDLE;
        endcase
    end

    assign rvalid = (r_state == R_RESP);

    // Read response captured at the AR handshake and held until accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= 32'd0;
            rresp <= RESP_OKAY;
        end else if (arready) begin
            rdata <= rd_data;
            rresp <= rd_resp;
        end
    end

    // Write FSM state register.
    always_ff @(posedge clk) begin
        if (rst) w_state <= W_IDLE;
        else w_state <= w_state_next;
    end

    // Write FSM next state; address and data are only accepted together.
    always_comb begin
        w_state_next = w_state;
        awready      = 1'b0;
        wready       = 1'b0;
        case (w_state)
            W_IDLE: begin
                if (awvalid && wvalid && !rst) begin
                    awready      = 1'b1;
                    wready       = 1'b1;
                    w_state_next = W_RESP;
                end
            end
            W_RESP: begin
                if (bready) w_state_next = W_IDLE;
            end
            default: w_state_next = W_IDLE;
        endcase
    end

    assign wr_en  = awready;
    assign bvalid = (w_state == W_RESP);

    always_ff @(posedge clk) begin
        if (rst) bresp <= RESP_OKAY;
        else if (wr_en) bresp <= (wr_sel.kind == REG_NONE) ? RESP_SLVERR : RESP_OKAY;
    end

    // msip and mtimecmp register writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            msip_q <= '0;
            for (int h = 0; h < MAX_HART; h++) mtimecmp[h] <= '1;
        end else if (wr_en) begin
            case (wr_sel.kind)
                REG_MSIP: begin
                    if (wstrb[0]) msip_q[wr_sel.hart] <= wdata[0];
                end
                REG_CMP_LO: mtimecmp[wr_sel.hart][31:0] <=
                                merge(mtimecmp[wr_sel.hart][31:0], wdata, wstrb);
                REG_CMP_HI: mtimecmp[wr_sel.hart][63:32] <=
                                merge(mtimecmp[wr_sel.hart][63:32], wdata, wstrb);
                default: ;
            endcase
        end
    end

    clint_timer #(
        .TICK_DIV (TICK_DIV)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .wr_lo (wr_en && (wr_sel.kind == REG_TIME_LO)),
        .wr_hi (wr_en && (wr_sel.kind == REG_TIME_HI)),
        .wdata (wdata),
        .wstrb (wstrb),
        .mtime (mtime)
    );

    // Timer interrupt compare, registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            mtip <= '0;
        end else begin
            for (int h = 0; h < NHART; h++) mtip[h] <= (mtime >= mtimecmp[h]);
        end
    end

    assign msip = msip_q[NHART-1:0];

endmodule
